dice_roller: RTL and testbench

DICE_ROLLER -- requirements
Module: dice_roller

---
 rtl/dice_roller.sv | 148 ++++++++++++++
 tb/tb_dice_roller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dice_roller.sv
// ============================================================================
//  Module   : dice_roller
//  Purpose  : Electronic die. While en is high the displayed face churns every
//             cycle from a free-running 8-bit LFSR. When en drops the face keeps
//             changing, but only every TICK_DIV cycles and SETTLE_STEPS times,
//             and the last of those faces is held as the final result.
//  Ports    : clk     - clock, all state changes on the rising edge
//             reset   - synchronous, active-high
//             en      - roll request (high while the upstream bar is full)
//             value   - die face, 0 = none, 1..6 = face
//             valid   - high while value is a final result
//             done    - one-cycle pulse when a result becomes final
//             rolling - high while rolling or settling
//             seg     - active-low seven-segment pattern {g,f,e,d,c,b,a}
//  Options  : DICE_SEG_EN - when defined, seg decodes value; otherwise seg is
//             tied to all-off and no decoder is built. Ports are the same
//             either way.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dice_roller #(
  parameter int TICK_DIV     = 4,
  parameter int SETTLE_STEPS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [2:0] value,
  output logic       valid,
  output logic       done,
  output logic       rolling,
  output logic [6:0] seg
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STEP_W = (SETTLE_STEPS > 1) ? $clog2(SETTLE_STEPS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  // The step counter never has to hold SETTLE_STEPS itself: the update that
  // would bring it there moves the FSM to SHOW instead.
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SETTLE_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROLL   = 2'd1,
    SETTLE = 2'd2,
    SHOW   = 2'd3
  } state_t;

  state_t              state;
  logic [7:0]          lfsr;
  logic [TICK_W-1:0]   tick;
  logic [STEP_W-1:0]   step;
  logic [7:0]          lfsr_next;
  logic [2:0]          candidate;

  // Maximal-length taps 8,6,5,4: starting from a non-zero seed the register
  // can never reach all-zero.
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign candidate = 3'(lfsr % 8'd6) + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      lfsr    <= 8'h01;
      tick    <= '0;
      step    <= '0;
      value   <= 3'd0;
      valid   <= 1'b0;
      done    <= 1'b0;
      rolling <= 1'b0;
    end else begin
      lfsr <= lfsr_next;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            state   <= ROLL;
            value   <= candidate;
            rolling <= 1'b1;
          end
        end
        ROLL: begin
          value <= candidate;
          if (!en) begin
            state <= SETTLE;
            tick  <= '0;
            step  <= '0;
          end
        end
        SETTLE: begin
          // A new request wins over a final update landing on the same edge.
          if (en) begin
            state <= ROLL;
            value <= candidate;
            tick  <= '0;
            step  <= '0;
          end else if (tick == TICK_LAST) begin
            value <= candidate;
            tick  <= '0;
            if (step == STEP_LAST) begin
              state   <= SHOW;
              step    <= '0;
              valid   <= 1'b1;
              done    <= 1'b1;
              rolling <= 1'b0;
            end else begin
              step <= step + STEP_W'(1);
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        SHOW: begin
          if (en) begin
            state   <= ROLL;
            value   <= candidate;
            valid   <= 1'b0;
            rolling <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DICE_SEG_EN
  always_comb begin
    seg = 7'b1111111;
    unique case (value)
      3'd1:    seg = 7'b1111001;
      3'd2:    seg = 7'b0100100;
      3'd3:    seg = 7'b0110000;
      3'd4:    seg = 7'b0011001;
      3'd5:    seg = 7'b0010010;
      3'd6:    seg = 7'b0000010;
      default: seg = 7'b1111111;
    endcase
  end
`else
  assign seg = 7'b1111111;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dice_roller.sv
// ============================================================================
//  Module   : tb_dice_roller
//  Purpose  : Self-checking bench for dice_roller (TICK_DIV=4, SETTLE_STEPS=3).
//             An independent LFSR model predicts every face; expected faces
//             are queued before each clock edge and popped after it.
//             Seg expectations follow DICE_SEG_EN when it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dice_roller;

  localparam int TD = 4;
  localparam int SS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [2:0] value;
  logic       valid;
  logic       done;
  logic       rolling;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_lfsr = 8'h01;
  int cur = 0;
  int exp_q[$];
  int faces[7];

  dice_roller #(.TICK_DIV(TD), .SETTLE_STEPS(SS)) dut (
    .clk(clk), .reset(reset), .en(en), .value(value), .valid(valid),
    .done(done), .rolling(rolling), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input int v);
`ifdef DICE_SEG_EN
    case (v)
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      default: return 7'b1111111;
    endcase
`else
    return 7'b1111111;
`endif
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic chk(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, queue the predicted face, clock, compare.
  task automatic cyc(input bit rst_i, input bit en_i, input bit upd,
                     input bit ev, input bit ed, input bit er, input bit idle,
                     input string tag);
    int e;
    reset = rst_i;
    en    = en_i;
    if (idle)     e = 0;
    else if (upd) e = int'(m_lfsr % 8'd6) + 1;
    else          e = cur;
    exp_q.push_back(e);
    @(posedge clk);
    m_lfsr = rst_i ? 8'h01 : lfsr_step(m_lfsr);
    #1;
    e   = exp_q.pop_front();
    cur = e;
    chk(tag, "value",   32'(value),   32'(e));
    chk(tag, "valid",   32'(valid),   32'(ev));
    chk(tag, "done",    32'(done),    32'(ed));
    chk(tag, "rolling", 32'(rolling), 32'(er));
    chk(tag, "seg",     32'(seg),     32'(seg_ref(e)));
    chk(tag, "lfsr",    32'(dut.lfsr), 32'(m_lfsr));
  endtask

  // w cycles with en high (each loads a face), then the edge that drops en.
  task automatic roll_phase(input int w, input string tag);
    for (int i = 0; i < w; i++) cyc(0, 1, 1, 0, 0, 1, 0, tag);
    cyc(0, 0, 1, 0, 0, 1, 0, tag);
  endtask

  // SETTLE cycles 1..n with en low; face updates every TD-th cycle.
  task automatic settle_phase(input int n, input string tag);
    for (int c = 1; c <= n; c++) begin
      bit fin;
      fin = (c == TD * SS);
      cyc(0, 0, (c % TD) == 0, fin, fin, !fin, 0, tag);
    end
  endtask

  task automatic show_hold(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0, 0, tag);
  endtask

  initial begin
    for (int f = 0; f < 7; f++) faces[f] = 0;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 1, "reset");
    cyc(1, 0, 0, 0, 0, 0, 1, "reset");

    // First roll after reset: face from lfsr=01 is 2
    cyc(0, 1, 1, 0, 0, 1, 0, "roll_first");
    chk("roll_first", "face2", 32'(value), 32'd2);
    roll_phase(4, "roll5");
    settle_phase(TD * SS, "settle");
    show_hold(2, "show");

    // Re-roll, abort at SETTLE cycle 6, then a full settle
    roll_phase(3, "reroll");
    settle_phase(5, "abort_pre");
    cyc(0, 1, 1, 0, 0, 1, 0, "abort");
    cyc(0, 0, 1, 0, 0, 1, 0, "abort_exit");
    settle_phase(TD * SS, "abort_settle");
    show_hold(1, "abort_show");

    // Reset in the middle of SETTLE, then reset priority over en
    roll_phase(2, "rst_roll");
    settle_phase(4, "rst_settle");
    cyc(1, 0, 0, 0, 0, 0, 1, "rst_mid");
    cyc(0, 0, 0, 0, 0, 0, 1, "rst_idle");
    cyc(1, 1, 0, 0, 0, 0, 1, "rst_pri");
    cyc(0, 1, 1, 0, 0, 1, 0, "rst_first");
    chk("rst_first", "face2", 32'(value), 32'd2);
    roll_phase(1, "rst_roll2");
    settle_phase(TD * SS, "rst_settle2");
    show_hold(1, "rst_show");

    // Random roll widths
    for (int r = 0; r < 1000; r++) begin
      roll_phase(int'($urandom_range(1, 6)), "rand_roll");
      settle_phase(TD * SS, "rand_settle");
      chk("rand", "in_range", 32'(value >= 3'd1 && value <= 3'd6), 32'd1);
      if (cur >= 1 && cur <= 6) faces[cur]++;
      show_hold(int'($urandom_range(1, 3)), "rand_show");
    end
    for (int f = 1; f <= 6; f++)
      chk($sformatf("face%0d", f), "count_ge_100", 32'(faces[f] >= 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
